sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, meaning SRAM byte-address width (1 kB).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the Wishbone wait-cycle limit (used only with SRAM_ARB_TIMEOUT_EN).
REQ-003 SHALL have one clock and one reset: i_clk  in  1  sole clock; i_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have core write ports: i_core_waddr  in  AW  byte address; i_core_wdata  in  8  write byte; i_core_wen  in  1  write strobe.
REQ-005 SHALL have core read ports: i_core_raddr  in  AW  byte address; i_core_ren  in  1  read strobe; o_core_rdata  out  8  read byte.
REQ-006 SHALL have Wishbone ports: i_wb_adr  in  AW  byte address, bits [1:0] ignored; i_wb_dat  in  32  write data; i_wb_sel  in  4  byte enables; i_wb_we  in  1  write; i_wb_stb  in  1  cyc&stb.
REQ-007 SHALL have Wishbone return ports: o_wb_rdt  out  32  read data; o_wb_ack  out  1  ack; o_wb_err  out  1  timeout error.
REQ-008 SHALL have SRAM port-0 ports: o_sram_csb0  out  1  select, active-low; o_sram_wmask0  out  4  lane mask; o_sram_addr0  out  AW-2  word address; o_sram_din0  out  32  write data.
REQ-009 SHALL have SRAM port-1 ports: o_sram_csb1  out  1  select, active-low; o_sram_addr1  out  AW-2  word address; i_sram_dout1  in  32  read data, valid one cycle after select.

Function
REQ-010 SHALL give the core absolute priority on both ports; the core is never stalled.
REQ-011 SHALL, for a core write, drive the same cycle: csb0=0, wmask0=1<<waddr[1:0], addr0=waddr[AW-1:2], din0={4{wdata}}.
REQ-012 SHALL, for a core read, drive csb1=0 and addr1=raddr[AW-1:2] the same cycle, and register raddr[1:0] as bsel.
REQ-013 SHALL drive o_core_rdata = i_sram_dout1[bsel*8+:8] one cycle after i_core_ren.
REQ-014 SHALL run a Wishbone FSM with states IDLE, WR_WAIT, RD_WAIT, RD_DATA, ACK.
REQ-015 SHALL, from IDLE with stb&we, issue on port 0 (wmask0=sel, din0=dat) and go to ACK if !i_core_wen; otherwise go to WR_WAIT.
REQ-016 SHALL, from IDLE with stb&!we, issue on port 1 and go to RD_DATA if !i_core_ren; otherwise go to RD_WAIT.
REQ-017 SHALL, in WR_WAIT/RD_WAIT, issue the access in the first cycle the core leaves the port free, then take the REQ-015/016 transition.
REQ-018 SHALL, in RD_DATA, register i_sram_dout1 into o_wb_rdt and go to ACK.
REQ-019 SHALL, in ACK, assert o_wb_ack for exactly one cycle and return to IDLE; stb is not re-sampled in ACK.
REQ-020 SHALL give write latency of ack at issue+1 and read latency of ack at issue+2.
REQ-021 SHALL, on a write with sel==0, go directly to ACK with no SRAM select.
REQ-022 SHALL, if stb drops in WR_WAIT/RD_WAIT, return to IDLE with no access and no ack.
REQ-023 SHALL hold o_wb_rdt between reads.
REQ-024 SHALL keep a wait counter that increments in WAIT states, saturates at TIMEOUT, and clears on leaving WAIT.

Reset
REQ-025 SHALL, while i_rst=1, force csb0=csb1=1 regardless of inputs.
REQ-026 SHALL reset state=IDLE, o_wb_ack=0, o_wb_err=0, o_wb_rdt=0, bsel=0, wait counter=0.
REQ-027 SHALL, on reset asserted mid-transaction, abandon the transaction with no ack after release.

Configuration
REQ-028 SHALL, with SRAM_ARB_TIMEOUT_EN defined, on the wait counter reaching TIMEOUT, pulse o_wb_err for one cycle instead of ack, with no access, then go to IDLE.
REQ-029 SHALL, without SRAM_ARB_TIMEOUT_EN, wait indefinitely; o_wb_err is tied 0 and the port is still present.

Structure
REQ-030 SHALL place FSM state encodings, SRAM word-address width (AW-2) and lane width (8) in shared package sram_arb_pkg.
REQ-031 SHALL place the core byte/word adaptation (REQ-011..013, bsel register) in sub-module sram_byte_lane.

Verification
REQ-032 SHALL cover: core write waddr=0x005, wdata=0xA5 -> same cycle csb0=0, wmask0=4'b0010, addr0=1, din0=0xA5A5A5A5.
REQ-033 SHALL cover: core read raddr=0x007 with dout1=0x11223344 -> o_core_rdata=0x11 next cycle.
REQ-034 SHALL cover: Wishbone write adr=0x010, dat=0xDEADBEEF, sel=4'b1111, core idle -> addr0=4 at cycle 0, ack at cycle 1; readback -> o_wb_rdt=0xDEADBEEF, ack at issue+2.
REQ-035 SHALL cover: Wishbone read while i_core_ren is high for 3 cycles -> port-1 issue on cycle 3, ack on cycle 5, core reads unaffected.
REQ-036 SHALL cover: with SRAM_ARB_TIMEOUT_EN and TIMEOUT=4, i_core_wen held high during a Wishbone write -> o_wb_err pulse, no ack, no Wishbone write.
REQ-037 SHALL cover: i_rst asserted in RD_DATA -> ack=0, rdt=0, csb0/csb1=1; no ack after release.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: Wishbone FSM state encoding,
// byte-lane width and the byte-to-word address width helper.
package sram_arb_pkg;

   localparam int LANE_W     = 8;   // one byte lane
   localparam int LANES      = 4;   // byte lanes per SRAM word
   localparam int BYTE_OFS_W = 2;   // byte offset bits inside a word

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_WAIT = 3'd1,
      S_RD_WAIT = 3'd2,
      S_RD_DATA = 3'd3,
      S_ACK     = 3'd4
   } wb_state_e;

   // SRAM word-address width for a given byte-address width
   function automatic int word_aw(input int aw);
      return aw - BYTE_OFS_W;
   endfunction

endpackage

// File: rtl/sram_byte_lane.sv
// Core-side byte/word adaptation: turns byte writes into a one-hot lane write
// of a replicated byte, and picks the requested byte out of the word read
// one cycle after the read strobe.
module sram_byte_lane
   import sram_arb_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [AW-1:0]     i_waddr,
   input  logic [LANE_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   input  logic              i_ren,
   input  logic [31:0]       i_dout1,
   output logic [3:0]        o_wmask,
   output logic [AW-3:0]     o_waddr,
   output logic [31:0]       o_din,
   output logic [AW-3:0]     o_raddr,
   output logic [LANE_W-1:0] o_rdata
);

   logic [1:0] bsel_q, bsel_d;

   // Address split, lane mask, byte replication and read byte select
   always_comb begin
      o_wmask = 4'b0001 << i_waddr[1:0];
      o_waddr = i_waddr[AW-1:BYTE_OFS_W];
      o_din   = {LANES{i_wdata}};
      o_raddr = i_raddr[AW-1:BYTE_OFS_W];
      bsel_d  = i_ren ? i_raddr[1:0] : bsel_q;
      o_rdata = i_dout1[{bsel_q, 3'b000} +: LANE_W];
   end

   // Remember which byte lane the in-flight read wants
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) bsel_q <= '0;
      else       bsel_q <= bsel_d;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a dual-port SRAM (port 0 write, port 1 read) between a byte-wide core
// with absolute priority and a 32-bit Wishbone slave that waits for free slots.
// Optional: define SRAM_ARB_TIMEOUT_EN to abort a Wishbone access with
// o_wb_err once it has waited TIMEOUT cycles; otherwise it waits forever.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW      = 10,
   parameter int TIMEOUT = 64
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [AW-1:0] i_core_waddr,
   input  logic [7:0]    i_core_wdata,
   input  logic          i_core_wen,
   input  logic [AW-1:0] i_core_raddr,
   input  logic          i_core_ren,
   output logic [7:0]    o_core_rdata,
   input  logic [AW-1:0] i_wb_adr,
   input  logic [31:0]   i_wb_dat,
   input  logic [3:0]    i_wb_sel,
   input  logic          i_wb_we,
   input  logic          i_wb_stb,
   output logic [31:0]   o_wb_rdt,
   output logic          o_wb_ack,
   output logic          o_wb_err,
   output logic          o_sram_csb0,
   output logic [3:0]    o_sram_wmask0,
   output logic [AW-3:0] o_sram_addr0,
   output logic [31:0]   o_sram_din0,
   output logic          o_sram_csb1,
   output logic [AW-3:0] o_sram_addr1,
   input  logic [31:0]   i_sram_dout1
);

   localparam int WAW = word_aw(AW);
   localparam int CW  = $clog2(TIMEOUT + 1);

   wb_state_e      state_q, state_d;
   logic           ack_q, ack_d;
   logic           err_q, err_d;
   logic [31:0]    rdt_q, rdt_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           cnt_sat, tmo_hit;
   logic           wb_wr_go, wb_rd_go;
   logic [3:0]     core_wmask;
   logic [WAW-1:0] core_waddr_w, core_raddr_w;
   logic [31:0]    core_din;
   logic           unused_adr;

   assign unused_adr = ^i_wb_adr[1:0];

   sram_byte_lane #(.AW(AW)) u_lane (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_waddr (i_core_waddr),
      .i_wdata (i_core_wdata),
      .i_raddr (i_core_raddr),
      .i_ren   (i_core_ren),
      .i_dout1 (i_sram_dout1),
      .o_wmask (core_wmask),
      .o_waddr (core_waddr_w),
      .o_din   (core_din),
      .o_raddr (core_raddr_w),
      .o_rdata (o_core_rdata)
   );

`ifdef SRAM_ARB_TIMEOUT_EN
   assign tmo_hit  = (cnt_q == CW'(TIMEOUT));
   assign o_wb_err = err_q;
`else
   logic unused_err;
   assign tmo_hit    = 1'b0;
   assign o_wb_err   = 1'b0;
   assign unused_err = err_q;
`endif

   assign o_wb_ack = ack_q;
   assign o_wb_rdt = rdt_q;

   // Wishbone next-state: issue only into cycles the core leaves free
   always_comb begin
      state_d  = state_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      rdt_d    = rdt_q;
      cnt_d    = '0;
      wb_wr_go = 1'b0;
      wb_rd_go = 1'b0;
      cnt_sat  = (cnt_q == CW'(TIMEOUT));
      unique case (state_q)
         S_IDLE, S_WR_WAIT, S_RD_WAIT: begin
            if (!i_wb_stb) begin
               state_d = S_IDLE;
            end else if (i_wb_we) begin
               if (i_wb_sel == 4'd0) begin
                  state_d = S_ACK;                 // nothing to write
                  ack_d   = 1'b1;
               end else if (!i_core_wen) begin
                  wb_wr_go = 1'b1;
                  state_d  = S_ACK;
                  ack_d    = 1'b1;
               end else if (state_q != S_IDLE && tmo_hit) begin
                  state_d = S_ACK;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_WR_WAIT;
                  if (state_q != S_IDLE) cnt_d = cnt_sat ? cnt_q : cnt_q + 1'b1;
               end
            end else begin
               if (!i_core_ren) begin
                  wb_rd_go = 1'b1;
                  state_d  = S_RD_DATA;
               end else if (state_q != S_IDLE && tmo_hit) begin
                  state_d = S_ACK;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_RD_WAIT;
                  if (state_q != S_IDLE) cnt_d = cnt_sat ? cnt_q : cnt_q + 1'b1;
               end
            end
         end
         S_RD_DATA: begin
            rdt_d   = i_sram_dout1;
            state_d = S_ACK;
            ack_d   = 1'b1;
         end
         S_ACK:   state_d = S_IDLE;                // stb deliberately not sampled
         default: state_d = S_IDLE;
      endcase
   end

   // Wishbone FSM state and its registered outputs
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdt_q   <= rdt_d;
         cnt_q   <= cnt_d;
      end

   // SRAM port steering: core first, Wishbone in the gaps, nothing in reset
   always_comb begin
      o_sram_csb0   = i_rst | ~(i_core_wen | wb_wr_go);
      o_sram_wmask0 = i_core_wen ? core_wmask   : i_wb_sel;
      o_sram_addr0  = i_core_wen ? core_waddr_w : i_wb_adr[AW-1:BYTE_OFS_W];
      o_sram_din0   = i_core_wen ? core_din     : i_wb_dat;
      o_sram_csb1   = i_rst | ~(i_core_ren | wb_rd_go);
      o_sram_addr1  = i_core_ren ? core_raddr_w : i_wb_adr[AW-1:BYTE_OFS_W];
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: stimulus pushes expected port-0,
// port-1, core-read and Wishbone responses (with their cycle) into queues;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_sram_port_arbiter;

   localparam int AW = 10;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [AW-1:0] i_core_waddr, i_core_raddr, i_wb_adr;
   logic [7:0]    i_core_wdata, o_core_rdata;
   logic          i_core_wen, i_core_ren;
   logic [31:0]   i_wb_dat, o_wb_rdt, o_sram_din0, i_sram_dout1;
   logic [3:0]    i_wb_sel, o_sram_wmask0;
   logic          i_wb_we, i_wb_stb, o_wb_ack, o_wb_err;
   logic          o_sram_csb0, o_sram_csb1;
   logic [AW-3:0] o_sram_addr0, o_sram_addr1;

   sram_port_arbiter #(.AW(AW), .TIMEOUT(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_core_waddr(i_core_waddr), .i_core_wdata(i_core_wdata), .i_core_wen(i_core_wen),
      .i_core_raddr(i_core_raddr), .i_core_ren(i_core_ren), .o_core_rdata(o_core_rdata),
      .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
      .i_wb_stb(i_wb_stb), .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
      .o_sram_csb0(o_sram_csb0), .o_sram_wmask0(o_sram_wmask0), .o_sram_addr0(o_sram_addr0),
      .o_sram_din0(o_sram_din0), .o_sram_csb1(o_sram_csb1), .o_sram_addr1(o_sram_addr1),
      .i_sram_dout1(i_sram_dout1)
   );

   always #5 i_clk = ~i_clk;

   // ---------------- SRAM model ----------------
   logic [31:0] mem [256];
   logic        mem_clr;
   always @(posedge i_clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem[1] <= 32'h1122_3344;
      end else begin
         if (!o_sram_csb0)
            for (int l = 0; l < 4; l++)
               if (o_sram_wmask0[l]) mem[o_sram_addr0][l*8 +: 8] <= o_sram_din0[l*8 +: 8];
         if (!o_sram_csb1) i_sram_dout1 <= mem[o_sram_addr1];
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {int c; logic [3:0] m; logic [7:0] a; logic [31:0] d;} p0_t;
   typedef struct {int c; logic [7:0] a;} p1_t;
   typedef struct {int c; logic [7:0] d;} rd_t;
   typedef struct {int c; logic err; logic [31:0] rdt;} wb_t;
   p0_t q0[$];
   p1_t q1[$];
   rd_t qr[$];
   wb_t qw[$];

   int n_chk = 0, n_fail = 0, cyc = 0;
   logic [31:0] last_rdt;
   logic ren_d;

   always @(posedge i_clk) cyc <= cyc + 1;
   always @(posedge i_clk) ren_d <= i_core_ren & ~i_rst;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic unexp(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got an unexpected event at cycle %0d, required none", nm, cyc);
   endtask

   task automatic e_p0(input int c, input logic [3:0] m, input logic [7:0] a, input logic [31:0] d);
      q0.push_back('{c, m, a, d});
   endtask
   task automatic e_p1(input int c, input logic [7:0] a);
      q1.push_back('{c, a});
   endtask
   task automatic e_rd(input int c, input logic [7:0] d);
      qr.push_back('{c, d});
   endtask
   task automatic e_wb(input int c, input logic err, input logic [31:0] rdt);
      qw.push_back('{c, err, rdt});
   endtask

   p0_t x0;
   p1_t x1;
   rd_t xr;
   wb_t xw;

   // monitor: every DUT output event must match the head of its queue
   always @(negedge i_clk) begin
      if (!i_rst && !mem_clr) begin
         if (!o_sram_csb0) begin
            if (q0.size() == 0) unexp("port0_access");
            else begin
               x0 = q0.pop_front();
               chk("port0_cycle", cyc, x0.c);
               chk("port0_wmask", 32'(o_sram_wmask0), 32'(x0.m));
               chk("port0_addr", 32'(o_sram_addr0), 32'(x0.a));
               chk("port0_din", o_sram_din0, x0.d);
            end
         end
         if (!o_sram_csb1) begin
            if (q1.size() == 0) unexp("port1_access");
            else begin
               x1 = q1.pop_front();
               chk("port1_cycle", cyc, x1.c);
               chk("port1_addr", 32'(o_sram_addr1), 32'(x1.a));
            end
         end
         if (ren_d) begin
            if (qr.size() == 0) unexp("core_rdata");
            else begin
               xr = qr.pop_front();
               chk("core_rd_cycle", cyc, xr.c);
               chk("core_rdata", 32'(o_core_rdata), 32'(xr.d));
            end
         end
         if (o_wb_ack || o_wb_err) begin
            if (qw.size() == 0) unexp("wb_response");
            else begin
               xw = qw.pop_front();
               chk("wb_resp_cycle", cyc, xw.c);
               chk("wb_err", 32'(o_wb_err), 32'(xw.err));
               chk("wb_ack", 32'(o_wb_ack), 32'(!xw.err));
               chk("wb_rdt", o_wb_rdt, xw.rdt);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic wb_set(input logic stb, input logic we, input logic [AW-1:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
      i_wb_stb = stb; i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
   endtask

   int c;

   initial begin
      // reset with everything requesting: both selects must stay high
      i_rst = 1'b1; mem_clr = 1'b1;
      i_core_wen = 1'b1; i_core_waddr = '0; i_core_wdata = 8'hFF;
      i_core_ren = 1'b1; i_core_raddr = '0;
      wb_set(1'b1, 1'b1, '0, '1, 4'hF);
      last_rdt = '0;
      tick(2);
      @(negedge i_clk);
      chk("rst_csb0", 32'(o_sram_csb0), 32'd1);
      chk("rst_csb1", 32'(o_sram_csb1), 32'd1);
      chk("rst_ack", 32'(o_wb_ack), 32'd0);
      chk("rst_err", 32'(o_wb_err), 32'd0);
      chk("rst_rdt", o_wb_rdt, 32'd0);
      tick();
      i_core_wen = 1'b0; i_core_ren = 1'b0; wb_set(1'b0, 1'b0, '0, '0, 4'h0);
      i_rst = 1'b0; mem_clr = 1'b0;

      // core read of byte 3 of word 1 (0x11223344)
      tick(); c = cyc;
      i_core_ren = 1'b1; i_core_raddr = 10'h007; e_p1(c, 8'd1); e_rd(c + 1, 8'h11);
      tick(); c = cyc;
      i_core_ren = 1'b0;
      // core byte write 0xA5 to 0x005 -> lane 1 of word 1
      i_core_wen = 1'b1; i_core_waddr = 10'h005; i_core_wdata = 8'hA5;
      e_p0(c, 4'b0010, 8'd1, 32'hA5A5_A5A5);
      tick(); c = cyc;
      i_core_wen = 1'b0;
      // back-to-back core reads, word 1 now 0x1122A544
      i_core_ren = 1'b1; i_core_raddr = 10'h005; e_p1(c, 8'd1); e_rd(c + 1, 8'hA5);
      tick();
      i_core_raddr = 10'h004; e_p1(c + 1, 8'd1); e_rd(c + 2, 8'h44);
      tick();
      i_core_ren = 1'b0;

      // Wishbone full-word write, core idle: issue now, ack next cycle
      tick(); c = cyc;
      wb_set(1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF);
      e_p0(c, 4'hF, 8'd4, 32'hDEAD_BEEF); e_wb(c + 1, 1'b0, last_rdt);
      tick(2); wb_set(1'b0, 1'b0, '0, '0, 4'h0);
      // readback: ack two cycles after issue
      tick(); c = cyc;
      wb_set(1'b1, 1'b0, 10'h010, '0, 4'hF);
      e_p1(c, 8'd4); e_wb(c + 2, 1'b0, 32'hDEAD_BEEF); last_rdt = 32'hDEAD_BEEF;
      tick(3); wb_set(1'b0, 1'b0, '0, '0, 4'h0);

      // Wishbone read of word 1 while the core reads for 3 cycles
      tick(); c = cyc;
      wb_set(1'b1, 1'b0, 10'h004, '0, 4'hF);
      i_core_ren = 1'b1; i_core_raddr = 10'h010; e_p1(c, 8'd4); e_rd(c + 1, 8'hEF);
      tick(); i_core_raddr = 10'h011; e_p1(c + 1, 8'd4); e_rd(c + 2, 8'hBE);
      tick(); i_core_raddr = 10'h013; e_p1(c + 2, 8'd4); e_rd(c + 3, 8'hDE);
      tick(); i_core_ren = 1'b0;
      e_p1(c + 3, 8'd1); e_wb(c + 5, 1'b0, 32'h1122_A544); last_rdt = 32'h1122_A544;
      tick(3); wb_set(1'b0, 1'b0, '0, '0, 4'h0);

      // sel==0 write: ack with no SRAM select, rdt held
      tick(); c = cyc;
      wb_set(1'b1, 1'b1, 10'h018, 32'hFFFF_FFFF, 4'h0); e_wb(c + 1, 1'b0, last_rdt);
      tick(2); wb_set(1'b0, 1'b0, '0, '0, 4'h0);

      // partial-lane write (lanes 0 and 2) then core reads lanes 2 and 1
      tick(); c = cyc;
      wb_set(1'b1, 1'b1, 10'h014, 32'h1234_5678, 4'b0101);
      e_p0(c, 4'b0101, 8'd5, 32'h1234_5678); e_wb(c + 1, 1'b0, last_rdt);
      tick(2); wb_set(1'b0, 1'b0, '0, '0, 4'h0); c = cyc;
      i_core_ren = 1'b1; i_core_raddr = 10'h016; e_p1(c, 8'd5); e_rd(c + 1, 8'h34);
      tick(); i_core_raddr = 10'h015; e_p1(c + 1, 8'd5); e_rd(c + 2, 8'h00);
      tick(); i_core_ren = 1'b0;

      // stb dropped while waiting: no access, no ack
      tick(); c = cyc;
      i_core_wen = 1'b1; i_core_waddr = 10'h020; i_core_wdata = 8'h77;
      e_p0(c, 4'b0001, 8'd8, 32'h7777_7777);
      wb_set(1'b1, 1'b1, 10'h030, 32'h0BAD_0BAD, 4'hF);
      tick(); i_core_wen = 1'b0; wb_set(1'b0, 1'b0, '0, '0, 4'h0);
      tick(3);

      // write blocked two cycles, issued in the first free cycle
      c = cyc;
      i_core_wen = 1'b1; i_core_waddr = 10'h021; i_core_wdata = 8'h66;
      e_p0(c, 4'b0010, 8'd8, 32'h6666_6666);
      wb_set(1'b1, 1'b1, 10'h024, 32'hCAFE_F00D, 4'hF);
      tick(); i_core_waddr = 10'h022; i_core_wdata = 8'h55;
      e_p0(c + 1, 4'b0100, 8'd8, 32'h5555_5555);
      tick(); i_core_wen = 1'b0;
      e_p0(c + 2, 4'hF, 8'd9, 32'hCAFE_F00D); e_wb(c + 3, 1'b0, last_rdt);
      tick(2); wb_set(1'b0, 1'b0, '0, '0, 4'h0);
      tick();

      // core holds port 0 during a Wishbone write
      c = cyc;
      wb_set(1'b1, 1'b1, 10'h02C, 32'hBAD0_BAD0, 4'hF);
      i_core_wen = 1'b1; i_core_waddr = 10'h028; i_core_wdata = 8'h3C;
`ifdef SRAM_ARB_TIMEOUT_EN
      for (int k = 0; k < 6; k++) begin
         e_p0(c + k, 4'b0001, 8'd10, 32'h3C3C_3C3C);
         tick();
      end
      i_core_wen = 1'b0; e_wb(c + 6, 1'b1, last_rdt);
      tick(); wb_set(1'b0, 1'b0, '0, '0, 4'h0);
`else
      for (int k = 0; k < 8; k++) begin
         e_p0(c + k, 4'b0001, 8'd10, 32'h3C3C_3C3C);
         tick();
      end
      i_core_wen = 1'b0;
      e_p0(c + 8, 4'hF, 8'd11, 32'hBAD0_BAD0); e_wb(c + 9, 1'b0, last_rdt);
      tick(2); wb_set(1'b0, 1'b0, '0, '0, 4'h0);
`endif
      tick(2);

      // reset while in RD_DATA: transaction abandoned
      c = cyc;
      wb_set(1'b1, 1'b0, 10'h024, '0, 4'hF); e_p1(c, 8'd9);
      tick();
      i_rst = 1'b1; wb_set(1'b0, 1'b0, '0, '0, 4'h0);
      i_core_wen = 1'b1; i_core_ren = 1'b1;
      @(negedge i_clk);
      chk("midrst_ack", 32'(o_wb_ack), 32'd0);
      chk("midrst_rdt", o_wb_rdt, 32'd0);
      chk("midrst_csb0", 32'(o_sram_csb0), 32'd1);
      chk("midrst_csb1", 32'(o_sram_csb1), 32'd1);
      tick();
      i_core_wen = 1'b0; i_core_ren = 1'b0; i_rst = 1'b0; last_rdt = '0;
      tick(4);
      // recovery read of the word written earlier
      c = cyc;
      wb_set(1'b1, 1'b0, 10'h024, '0, 4'hF);
      e_p1(c, 8'd9); e_wb(c + 2, 1'b0, 32'hCAFE_F00D);
      tick(3); wb_set(1'b0, 1'b0, '0, '0, 4'h0);
      tick(3);

      // every expected event must have been seen
      chk("q_port0_left", 32'(q0.size()), 32'd0);
      chk("q_port1_left", 32'(q1.size()), 32'd0);
      chk("q_rdata_left", 32'(qr.size()), 32'd0);
      chk("q_wb_left", 32'(qw.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
